// File: rtl/branch_history_predictor.sv
// Branch history predictor: a table of 2-bit saturating counters indexed by
// branch jump address. It answers fetch-stage prediction queries in the same
// cycle, trains on final outcomes from several resolve channels, and issues a
// registered PC-recover request with stage-clean mask on a mispredict.
// Interrupt or restart handling sweeps the whole table back to INIT_STATE.
module branch_history_predictor #(
    parameter int ADDR_W        = 40,
    parameter int ENTRIES       = 64,
    parameter int IDX_LSB       = 2,
    parameter int RESOLVE_PORTS = 2,
    parameter int INIT_STATE    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              askInterHandle,
    input  logic                              askRestartHandle,
    input  logic                              qry_valid,
    input  logic [ADDR_W-1:0]                 qry_addr,
    output logic                              pred_taken,
    output logic                              init_busy,
    input  logic [RESOLVE_PORTS-1:0]          res_valid,
    input  logic [RESOLVE_PORTS*ADDR_W-1:0]   res_addr,
    input  logic [RESOLVE_PORTS-1:0]          res_taken,
    input  logic [RESOLVE_PORTS-1:0]          res_pred,
    input  logic [RESOLVE_PORTS*ADDR_W-1:0]   res_target,
    output logic                              recover_valid,
    output logic [ADDR_W-1:0]                 recover_addr,
    output logic [RESOLVE_PORTS:0]            clean_mask
);

    localparam int               IDX_W    = $clog2(ENTRIES);
    localparam int               RP       = RESOLVE_PORTS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [1:0]       INIT_VAL = 2'(INIT_STATE);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  init_cnt;
    logic [1:0]        cnt_table [ENTRIES];

    logic              run;
    logic              restart_req;
    logic [RP-1:0]     survive;
    logic              mis_any;
    logic [ADDR_W-1:0] mis_target;
    logic [RP:0]       mis_mask;

    // Prediction carries no state, and only the index bits of the addresses
    // matter; the remaining bits are collected here so they are visibly unused.
    logic unused_inputs;
    assign unused_inputs = ^{qry_valid, qry_addr, res_addr};

    assign run         = (state == ST_RUN);
    assign restart_req = askInterHandle | askRestartHandle;
    assign init_busy   = (state == ST_INIT);

    // Query reads the pre-update counter; the MSB is the taken prediction.
    assign pred_taken  = run & cnt_table[qry_addr[IDX_LSB +: IDX_W]][1];

    // Move a counter one step towards the outcome, saturating at 0 and 3.
    function automatic logic [1:0] step_counter(input logic [1:0] value, input logic up);
        if (up) begin
            return (value == 2'd3) ? value : value + 2'd1;
        end
        return (value == 2'd0) ? value : value - 2'd1;
    endfunction

    // Find the oldest mispredicting channel; younger channels are squashed,
    // so only that channel and older ones survive for training.
    always_comb begin
        mis_any    = 1'b0;
        mis_target = '0;
        mis_mask   = '0;
        survive    = '0;
        for (int k = RP - 1; k >= 0; k--) begin
            survive[k] = res_valid[k] & ~mis_any;
            if (run && !mis_any && res_valid[k] && (res_taken[k] != res_pred[k])) begin
                mis_any    = 1'b1;
                mis_target = res_target[k*ADDR_W +: ADDR_W];
                for (int j = 0; j <= RP; j++) begin
                    mis_mask[j] = (j <= k);
                end
            end
        end
    end

    // Init sweep / run FSM owning the counter table; ascending channel order
    // lets the oldest surviving channel win when indices collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            cnt_table[init_cnt] <= INIT_VAL;
            if (restart_req) begin
                init_cnt <= '0;
            end else if (init_cnt == LAST_IDX) begin
                state <= ST_RUN;
            end else begin
                init_cnt <= init_cnt + IDX_W'(1);
            end
        end else begin
            if (restart_req) begin
                state    <= ST_INIT;
                init_cnt <= '0;
            end else begin
                for (int k = 0; k < RP; k++) begin
                    if (survive[k]) begin
                        cnt_table[res_addr[k*ADDR_W + IDX_LSB +: IDX_W]] <=
                            step_counter(cnt_table[res_addr[k*ADDR_W + IDX_LSB +: IDX_W]],
                                         res_taken[k]);
                    end
                end
            end
        end
    end

    // Register the recover request so it pulses for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            recover_valid <= 1'b0;
            recover_addr  <= '0;
            clean_mask    <= '0;
        end else begin
            recover_valid <= mis_any;
            recover_addr  <= mis_target;
            clean_mask    <= mis_mask;
        end
    end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Self-checking bench for branch_history_predictor: directed scenarios followed
// by randomized traffic, compared against a table-level reference model.
module tb_branch_history_predictor;

    localparam int ADDR_W     = 40;
    localparam int ENTRIES    = 64;
    localparam int IDX_LSB    = 2;
    localparam int RP         = 2;
    localparam int INIT_STATE = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ask_inter;
    logic                 ask_restart;
    logic                 qry_valid;
    logic [ADDR_W-1:0]    qry_addr;
    logic                 pred_taken;
    logic                 init_busy;
    logic [RP-1:0]        res_valid;
    logic [RP*ADDR_W-1:0] res_addr;
    logic [RP-1:0]        res_taken;
    logic [RP-1:0]        res_pred;
    logic [RP*ADDR_W-1:0] res_target;
    logic                 recover_valid;
    logic [ADDR_W-1:0]    recover_addr;
    logic [RP:0]          clean_mask;

    int n_compared   = 0;
    int n_mismatched = 0;

    int                mtab [ENTRIES];
    int                init_left = 0;
    bit                model_known = 1'b0;
    logic              exp_rv;
    logic [ADDR_W-1:0] exp_ra;
    logic [RP:0]       exp_cm;

    branch_history_predictor #(
        .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .IDX_LSB(IDX_LSB),
        .RESOLVE_PORTS(RP), .INIT_STATE(INIT_STATE)
    ) dut (
        .clk(clk), .rst(rst),
        .askInterHandle(ask_inter), .askRestartHandle(ask_restart),
        .qry_valid(qry_valid), .qry_addr(qry_addr),
        .pred_taken(pred_taken), .init_busy(init_busy),
        .res_valid(res_valid), .res_addr(res_addr), .res_taken(res_taken),
        .res_pred(res_pred), .res_target(res_target),
        .recover_valid(recover_valid), .recover_addr(recover_addr),
        .clean_mask(clean_mask)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [ADDR_W-1:0] a);
        return int'((a >> IDX_LSB) % ENTRIES);
    endfunction

    function automatic logic model_pred(input logic [ADDR_W-1:0] a);
        return (mtab[idx_of(a)] >= 2);
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [63:0] r;
        r      = {$urandom(), $urandom()};
        r[7:2] = 6'($urandom_range(0, 7));
        return r[ADDR_W-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_table();
        foreach (mtab[i]) mtab[i] = INIT_STATE;
        init_left = ENTRIES;
    endtask

    task automatic clear_res();
        res_valid  = '0;
        res_addr   = '0;
        res_taken  = '0;
        res_pred   = '0;
        res_target = '0;
    endtask

    task automatic set_ch(input int k, input logic [ADDR_W-1:0] a, input logic t,
                          input logic p, input logic [ADDR_W-1:0] tg);
        res_valid[k]                   = 1'b1;
        res_addr[k*ADDR_W +: ADDR_W]   = a;
        res_taken[k]                   = t;
        res_pred[k]                    = p;
        res_target[k*ADDR_W +: ADDR_W] = tg;
    endtask

    // One clock cycle: check same-cycle outputs, advance the model, then
    // check the registered outputs after the edge.
    task automatic applyStimulus();
        int m;
        int win [ENTRIES];
        bit busy;
        bit ask;
        #1;
        busy = (init_left > 0);
        if (model_known && !rst) begin
            checkOutput("init_busy", 64'(init_busy), 64'(busy));
            checkOutput("pred_taken", 64'(pred_taken), 64'(!busy && model_pred(qry_addr)));
        end
        ask = ask_inter | ask_restart;
        if (rst) begin
            fill_table();
            exp_rv = 1'b0;
            exp_ra = '0;
            exp_cm = '0;
        end else begin
            m = -1;
            if (!busy) begin
                for (int k = 0; k < RP; k++) begin
                    if (res_valid[k] && (res_taken[k] != res_pred[k])) m = k;
                end
            end
            exp_rv = (m >= 0);
            exp_ra = '0;
            exp_cm = '0;
            if (m >= 0) begin
                exp_ra = res_target[m*ADDR_W +: ADDR_W];
                for (int j = 0; j <= m; j++) exp_cm[j] = 1'b1;
            end
            if (busy) begin
                if (ask) init_left = ENTRIES;
                else init_left--;
            end else if (ask) begin
                fill_table();
            end else begin
                foreach (win[i]) win[i] = -1;
                for (int k = 0; k < RP; k++) begin
                    if (res_valid[k] && k >= m) win[idx_of(res_addr[k*ADDR_W +: ADDR_W])] = k;
                end
                for (int i = 0; i < ENTRIES; i++) begin
                    if (win[i] >= 0) begin
                        if (res_taken[win[i]]) mtab[i] = (mtab[i] >= 3) ? 3 : mtab[i] + 1;
                        else mtab[i] = (mtab[i] <= 0) ? 0 : mtab[i] - 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        model_known = 1'b1;
        checkOutput("recover_valid", 64'(recover_valid), 64'(exp_rv));
        checkOutput("recover_addr", 64'(recover_addr), 64'(exp_ra));
        checkOutput("clean_mask", 64'(clean_mask), 64'(exp_cm));
        if (!rst) checkOutput("init_busy_post", 64'(init_busy), 64'(init_left > 0));
    endtask

    initial begin
        rst         = 1'b1;
        ask_inter   = 1'b0;
        ask_restart = 1'b0;
        qry_valid   = 1'b0;
        qry_addr    = '0;
        clear_res();
        $display("[TB] reset");
        applyStimulus();
        rst = 1'b0;

        $display("[TB] init sweep with resolves that must be ignored");
        for (int i = 0; i < ENTRIES; i++) begin
            clear_res();
            qry_valid = 1'b1;
            qry_addr  = rand_addr();
            set_ch(0, rand_addr(), 1'b1, 1'b0, rand_addr());
            applyStimulus();
        end

        $display("[TB] first mispredict on ch0");
        clear_res();
        qry_addr = 40'h100;
        applyStimulus();
        set_ch(0, 40'h100, 1'b1, 1'b0, 40'h1234);
        applyStimulus();
        clear_res();
        applyStimulus();

        $display("[TB] saturation on 0x200");
        qry_addr = 40'h200;
        for (int i = 0; i < 4; i++) begin
            clear_res();
            set_ch(0, 40'h200, 1'b1, model_pred(40'h200), 40'h900);
            applyStimulus();
        end
        for (int i = 0; i < 5; i++) begin
            clear_res();
            set_ch(0, 40'h200, 1'b0, model_pred(40'h200), 40'h900);
            applyStimulus();
        end
        clear_res();
        applyStimulus();

        $display("[TB] dual mispredict");
        set_ch(0, 40'h300, 1'b1, 1'b0, 40'hA0);
        set_ch(1, 40'h400, 1'b0, 1'b1, 40'hB0);
        applyStimulus();
        clear_res();
        qry_addr = 40'h300;
        applyStimulus();

        $display("[TB] restart during mispredict");
        ask_restart = 1'b1;
        set_ch(1, 40'h500, 1'b1, 1'b0, 40'hC0);
        applyStimulus();
        ask_restart = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            clear_res();
            qry_addr = rand_addr();
            set_ch(1, rand_addr(), 1'b0, 1'b1, rand_addr());
            applyStimulus();
        end
        clear_res();
        applyStimulus();

        $display("[TB] aliasing 0x104 / 0x204");
        qry_addr = 40'h204;
        set_ch(0, 40'h104, 1'b1, 1'b0, 40'h10);
        applyStimulus();
        set_ch(0, 40'h104, 1'b1, 1'b1, 40'h10);
        applyStimulus();
        clear_res();
        applyStimulus();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            logic [ADDR_W-1:0] a;
            rst         = ($urandom_range(0, 249) == 0);
            ask_inter   = ($urandom_range(0, 79) == 0);
            ask_restart = ($urandom_range(0, 79) == 0);
            qry_valid   = 1'($urandom_range(0, 1));
            qry_addr    = rand_addr();
            clear_res();
            for (int k = 0; k < RP; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    a = rand_addr();
                    set_ch(k, a, 1'($urandom_range(0, 1)), 1'b0, rand_addr());
                    if ($urandom_range(0, 9) < 7) res_pred[k] = model_pred(a);
                    else res_pred[k] = 1'($urandom_range(0, 1));
                end
            end
            applyStimulus();
        end
        rst         = 1'b0;
        ask_inter   = 1'b0;
        ask_restart = 1'b0;
        clear_res();
        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
